// File: rtl/run_control.sv
// Front-panel run/stop/step sequencer feeding the clock module's stop/single_step/single_stepping inputs.
// Latency: raw input edge -> debounced level in 2 + DEBOUNCE_CYCLES cycles; state and registered outputs one cycle later.
// No backpressure: free-running, every input is sampled each clk_in cycle and outputs are plain registered levels.

// Two-flop synchronizer followed by a counting debouncer for one front-panel input.
module run_control_debounce #(
   parameter int unsigned CYCLES = 1000
) (
   input  logic clk_in,
   input  logic reset,
   input  logic raw_i,
   output logic level_o
);
   localparam int unsigned CW = $clog2(CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Accept the synchronized level only after it has disagreed for CYCLES consecutive cycles.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchronizer and debounce state registers.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
endmodule

module run_control #(
   parameter int unsigned DEBOUNCE_CYCLES   = 1000,
   parameter int unsigned STEP_PULSE_CYCLES = 4
) (
   input  logic clk_in,
   input  logic reset,
   input  logic run_switch,
   input  logic step_button,
   input  logic halt,
   input  logic cycle_done,
   output logic stop,
   output logic single_step,
   output logic single_stepping,
   output logic running,
   output logic halted
);
   localparam int unsigned PCW = $clog2(STEP_PULSE_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_STOPPED,
      ST_STEP_PULSE,
      ST_STEP_WAIT,
      ST_RUNNING,
      ST_DRAIN,
      ST_HALTED
   } state_t;

   state_t         state_q, state_d;
   logic [PCW-1:0] pulse_cnt_q;
   logic           run_lvl, step_lvl;
   logic           step_prev_q;
   logic           step_press;
   logic           stop_q, single_step_q, single_stepping_q, running_q, halted_q;

   run_control_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_run_deb (
      .clk_in  (clk_in),
      .reset   (reset),
      .raw_i   (run_switch),
      .level_o (run_lvl)
   );

   run_control_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step_deb (
      .clk_in  (clk_in),
      .reset   (reset),
      .raw_i   (step_button),
      .level_o (step_lvl)
   );

   // Remember the previous debounced button level so a held button yields a single press.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         step_prev_q <= 1'b0;
      end else begin
         step_prev_q <= step_lvl;
      end
   end

   assign step_press = step_lvl & ~step_prev_q;

   // Output encoding per state: {stop, single_step, single_stepping, running, halted}.
   function automatic logic [4:0] outs_for(input state_t s);
      logic [4:0] o;
      o = 5'b00100;
      case (s)
         ST_STOPPED:    o = 5'b00100;
         ST_STEP_PULSE: o = 5'b01100;
         ST_STEP_WAIT:  o = 5'b00100;
         ST_RUNNING:    o = 5'b00010;
         ST_DRAIN:      o = 5'b00010;
         ST_HALTED:     o = 5'b10101;
         default:       o = 5'b00100;
      endcase
      return o;
   endfunction

   // Next-state decode; halt overrides every other transition in the states where it is honoured.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_STOPPED: begin
            if (run_lvl) begin
               state_d = ST_RUNNING;
            end else if (step_press) begin
               state_d = ST_STEP_PULSE;
            end
         end
         ST_STEP_PULSE: begin
            if (halt) begin
               state_d = ST_HALTED;
            end else if (pulse_cnt_q == '0) begin
               state_d = ST_STEP_WAIT;
            end
         end
         ST_STEP_WAIT: begin
            if (halt) begin
               state_d = ST_HALTED;
            end else if (cycle_done) begin
               state_d = ST_STOPPED;
            end
         end
         ST_RUNNING: begin
            if (halt) begin
               state_d = ST_HALTED;
            end else if (!run_lvl) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Finishing the current machine cycle wins over the run switch coming back.
            if (halt) begin
               state_d = ST_HALTED;
            end else if (cycle_done) begin
               state_d = ST_STOPPED;
            end else if (run_lvl) begin
               state_d = ST_RUNNING;
            end
         end
         ST_HALTED: begin
            if (!run_lvl) begin
               state_d = ST_STOPPED;
            end
         end
         default: state_d = ST_STOPPED;
      endcase
   end

   // State register, step-pulse width counter and outputs registered alongside the state.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q           <= ST_STOPPED;
         pulse_cnt_q       <= '0;
         stop_q            <= 1'b0;
         single_step_q     <= 1'b0;
         single_stepping_q <= 1'b1;
         running_q         <= 1'b0;
         halted_q          <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q != ST_STEP_PULSE) && (state_d == ST_STEP_PULSE)) begin
            pulse_cnt_q <= PCW'(STEP_PULSE_CYCLES - 1);
         end else if ((state_q == ST_STEP_PULSE) && (pulse_cnt_q != '0)) begin
            pulse_cnt_q <= pulse_cnt_q - 1'b1;
         end
         {stop_q, single_step_q, single_stepping_q, running_q, halted_q} <= outs_for(state_d);
      end
   end

   assign stop            = stop_q;
   assign single_step     = single_step_q;
   assign single_stepping = single_stepping_q;
   assign running         = running_q;
   assign halted          = halted_q;
endmodule

// File: tb/tb_run_control.sv
// Bench for run_control: stimulus queues expected output changes with their cycle stamps;
// a monitor pops one entry on every change of the output vector and compares value and cycle.
// Output vector order: {stop, single_step, single_stepping, running, halted}.
module tb_run_control;
   logic clk_in      = 1'b0;
   logic reset       = 1'b0;
   logic run_switch  = 1'b0;
   logic step_button = 1'b0;
   logic halt        = 1'b0;
   logic cycle_done  = 1'b0;
   logic stop, single_step, single_stepping, running, halted;

   run_control #(
      .DEBOUNCE_CYCLES   (4),
      .STEP_PULSE_CYCLES (2)
   ) dut (
      .clk_in          (clk_in),
      .reset           (reset),
      .run_switch      (run_switch),
      .step_button     (step_button),
      .halt            (halt),
      .cycle_done      (cycle_done),
      .stop            (stop),
      .single_step     (single_step),
      .single_stepping (single_stepping),
      .running         (running),
      .halted          (halted)
   );

   localparam logic [4:0] V_STOPPED = 5'b00100;
   localparam logic [4:0] V_PULSE   = 5'b01100;
   localparam logic [4:0] V_RUN     = 5'b00010;
   localparam logic [4:0] V_HALTED  = 5'b10101;

   logic [4:0] ov;
   assign ov = {stop, single_step, single_stepping, running, halted};

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc = cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   logic [4:0] exp_vec_q[$];
   int         exp_cyc_q[$];
   string      exp_name_q[$];

   function automatic void push_exp(string name, logic [4:0] v, int c);
      exp_vec_q.push_back(v);
      exp_cyc_q.push_back(c);
      exp_name_q.push_back(name);
   endfunction

   task automatic tick(int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic check(string name, logic [4:0] got, logic [4:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: outputs %b, expected %b (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: every change of the output vector must match the next queued expectation.
   initial begin
      logic [4:0] prev;
      logic [4:0] ev;
      int         ec;
      string      en;
      prev = V_STOPPED;
      forever begin
         @(negedge clk_in);
         if (single_step === 1'b1) begin
            n_vec++;
            if (stop !== 1'b0 || single_stepping !== 1'b1) begin
               n_err++;
               $display("FAIL step_invariant: stop=%b single_stepping=%b while single_step=1 (cycle %0d)",
                        stop, single_stepping, cyc);
            end
         end
         if (ov !== prev) begin
            n_vec++;
            if (exp_vec_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_change: outputs %b at cycle %0d, expected to stay %b", ov, cyc, prev);
            end else begin
               ev = exp_vec_q.pop_front();
               ec = exp_cyc_q.pop_front();
               en = exp_name_q.pop_front();
               if (ov !== ev || cyc != ec) begin
                  n_err++;
                  $display("FAIL %s: outputs %b at cycle %0d, expected %b at cycle %0d", en, ov, cyc, ev, ec);
               end
            end
            prev = ov;
         end
      end
   end

   // Directed stimulus; latencies: raw edge driven after edge k -> state change on edge k+7.
   initial begin
      int k;
      #2 reset = 1'b1;
      tick(3);
      check("reset_outputs", ov, V_STOPPED);
      reset = 1'b0;
      tick(3);
      check("post_reset_idle", ov, V_STOPPED);

      // Step press with bounce: three short glitches then a clean held press.
      for (int i = 0; i < 3; i++) begin
         step_button = 1'b1; tick(2);
         step_button = 1'b0; tick(2);
      end
      step_button = 1'b1;
      k = cyc;
      push_exp("step_pulse_rise", V_PULSE, k + 7);
      push_exp("step_pulse_fall", V_STOPPED, k + 9);
      tick(20);
      step_button = 1'b0; tick(10);
      // Press while waiting for cycle_done is discarded.
      step_button = 1'b1; tick(10);
      step_button = 1'b0; tick(10);
      cycle_done = 1'b1; tick(1);
      cycle_done = 1'b0; tick(2);
      step_button = 1'b1;
      k = cyc;
      push_exp("step2_pulse_rise", V_PULSE, k + 7);
      push_exp("step2_pulse_fall", V_STOPPED, k + 9);
      tick(10);
      step_button = 1'b0; tick(10);
      cycle_done = 1'b1; tick(1);
      cycle_done = 1'b0; tick(2);

      // Reset in the middle of a step pulse drops single_step without a clock edge.
      step_button = 1'b1;
      tick(7);
      check("pulse_before_reset", ov, V_PULSE);
      #2 reset = 1'b1;
      step_button = 1'b0;
      #1 check("reset_async_drop", ov, V_STOPPED);
      tick(2);
      reset = 1'b0;
      tick(2);
      check("after_reset_release", ov, V_STOPPED);

      // Run then stop: DRAIN holds running until cycle_done.
      run_switch = 1'b1;
      k = cyc;
      push_exp("run_start", V_RUN, k + 7);
      tick(12);
      run_switch = 1'b0; tick(17);
      check("drain_still_running", ov, V_RUN);
      cycle_done = 1'b1;
      k = cyc;
      push_exp("drain_to_stopped", V_STOPPED, k + 1);
      tick(1);
      cycle_done = 1'b0; tick(3);

      // Halt while running, coincident with cycle_done.
      run_switch = 1'b1;
      k = cyc;
      push_exp("run_again", V_RUN, k + 7);
      tick(12);
      halt = 1'b1; cycle_done = 1'b1;
      k = cyc;
      push_exp("halt_in_run", V_HALTED, k + 1);
      tick(1);
      halt = 1'b0; cycle_done = 1'b0; tick(3);
      step_button = 1'b1; tick(10);
      step_button = 1'b0; tick(10);
      run_switch = 1'b0;
      k = cyc;
      push_exp("halt_ack", V_STOPPED, k + 7);
      tick(12);

      // Halt during the first cycle of a step pulse.
      step_button = 1'b1;
      k = cyc;
      push_exp("step_before_halt", V_PULSE, k + 7);
      tick(7);
      halt = 1'b1;
      push_exp("halt_in_pulse", V_HALTED, k + 8);
      push_exp("halted_release", V_STOPPED, k + 9);
      tick(1);
      halt = 1'b0; tick(10);
      step_button = 1'b0; tick(10);

      // Short run glitch is ignored; run and press together favour run.
      run_switch = 1'b1; tick(3);
      run_switch = 1'b0; tick(15);
      run_switch = 1'b1; step_button = 1'b1;
      k = cyc;
      push_exp("run_beats_step", V_RUN, k + 7);
      tick(12);
      step_button = 1'b0; run_switch = 1'b0; tick(12);
      cycle_done = 1'b1;
      k = cyc;
      push_exp("final_stop", V_STOPPED, k + 1);
      tick(1);
      cycle_done = 1'b0; tick(5);

      while (exp_vec_q.size() > 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: no output change seen, expected %b at cycle %0d",
                  exp_name_q[0], exp_vec_q[0], exp_cyc_q[0]);
         void'(exp_vec_q.pop_front());
         void'(exp_cyc_q.pop_front());
         void'(exp_name_q.pop_front());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
